// File: rtl/red_seq.sv
// rtl/red_seq.sv - multi-cycle signed byte reduction unit (sum of four bytes)
//
// Sums the four signed bytes of two 16-bit operands and returns the
// sign-extended 16-bit result four cycles after the accepting edge.
// A single 10-bit adder is time-shared across S1..S3.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous active-high reset
//   start  in   1  request, honoured only in IDLE or DONE
//   A      in  16  operand rs, captured on the accepting edge
//   B      in  16  operand rt, captured on the accepting edge
//   busy   out  1  high while the operation is in progress (S1..S4)
//   done   out  1  one-cycle pulse when Result becomes valid
//   Result out 16  sign-extended sum, held until the next completion
module red_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Result
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [8:0]  p_sum;
  logic [8:0]  q_sum;
  logic [9:0]  r_sum;
  logic [15:0] result_q;

  // Shared adder operands, steered by state.
  logic [9:0]  add_x;
  logic [9:0]  add_y;
  logic [9:0]  add_sum;

  // Next-state logic; accept is only possible from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_S1;
        end
      end
      ST_S1:   state_nxt = ST_S2;
      ST_S2:   state_nxt = ST_S3;
      ST_S3:   state_nxt = ST_S4;
      ST_S4:   state_nxt = ST_DONE;
      ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_S1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Adder input mux: high bytes in S1, low bytes in S2, partials in S3.
  always_comb begin
    add_x = 10'd0;
    add_y = 10'd0;
    case (state)
      ST_S1: begin
        add_x = {{2{op_a[15]}}, op_a[15:8]};
        add_y = {{2{op_b[15]}}, op_b[15:8]};
      end
      ST_S2: begin
        add_x = {{2{op_a[7]}}, op_a[7:0]};
        add_y = {{2{op_b[7]}}, op_b[7:0]};
      end
      ST_S3: begin
        add_x = {p_sum[8], p_sum};
        add_y = {q_sum[8], q_sum};
      end
      default: begin
        add_x = 10'd0;
        add_y = 10'd0;
      end
    endcase
  end

  assign add_sum = add_x + add_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= 16'd0;
      op_b     <= 16'd0;
      p_sum    <= 9'd0;
      q_sum    <= 9'd0;
      r_sum    <= 10'd0;
      result_q <= 16'd0;
    end else begin
      if (accept) begin
        op_a <= A;
        op_b <= B;
      end
      // Byte sums fit in 9 bits and the total in 10, so truncation is exact.
      if (state == ST_S1) p_sum <= add_sum[8:0];
      if (state == ST_S2) q_sum <= add_sum[8:0];
      if (state == ST_S3) r_sum <= add_sum;
      if (state == ST_S4) result_q <= {{6{r_sum[9]}}, r_sum};
    end
  end

  assign busy   = (state == ST_S1) || (state == ST_S2) ||
                  (state == ST_S3) || (state == ST_S4);
  assign done   = (state == ST_DONE);
  assign Result = result_q;

endmodule

// File: tb/tb_red_seq.sv
// tb/tb_red_seq.sv - directed self-checking bench for red_seq
//
// Drives directed operand vectors with hand-computed sums and checks the
// start/busy/done handshake, result hold, back-to-back issue and reset abort.
module tb_red_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Result;

  int errors;
  int checks;

  red_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic exp_busy, input logic exp_done);
    check({tag, ".busy"}, {15'd0, busy}, {15'd0, exp_busy});
    check({tag, ".done"}, {15'd0, done}, {15'd0, exp_done});
  endtask

  // Issue one operation from IDLE or DONE and check its full timeline.
  task automatic run_op(input string tag, input logic [15:0] a_val,
                        input logic [15:0] b_val, input logic [15:0] exp_res);
    start = 1'b1;
    A     = a_val;
    B     = b_val;
    tick();
    start = 1'b0;
    A     = 16'hDEAD;
    B     = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      check_flags({tag, ".mid"}, 1'b1, 1'b0);
      tick();
    end
    check_flags({tag, ".s4"}, 1'b1, 1'b0);
    tick();
    check_flags({tag, ".fin"}, 1'b0, 1'b1);
    check({tag, ".result"}, Result, exp_res);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A      = 16'h0000;
    B      = 16'h0000;
    tick();
    tick();
    check_flags("reset", 1'b0, 1'b0);
    check("reset.result", Result, 16'h0000);

    // Reset wins over start on the same edge.
    start = 1'b1;
    A     = 16'h0102;
    B     = 16'h0304;
    tick();
    check_flags("rst_prio", 1'b0, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    tick();

    // Basic: 1+2+3+4 = 10, with result hold afterwards.
    run_op("basic", 16'h0102, 16'h0304, 16'h000A);
    for (int i = 0; i < 10; i++) tick();
    check_flags("hold", 1'b0, 1'b0);
    check("hold.result", Result, 16'h000A);

    run_op("neg_ext", 16'h8080, 16'h8080, 16'hFE00);
    tick();
    run_op("pos_ext", 16'h7F7F, 16'h7F7F, 16'h01FC);
    tick();
    run_op("mixed", 16'hFF01, 16'h80FF, 16'hFF7F);
    tick();
    check("mixed.hold", Result, 16'hFF7F);

    // start pulsed in S2 is ignored and not queued.
    start = 1'b1;
    A     = 16'h0102;
    B     = 16'h0304;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    A     = 16'h7F7F;
    B     = 16'h7F7F;
    tick();
    start = 1'b0;
    check("ign.s3_result", Result, 16'hFF7F);
    tick();
    tick();
    check_flags("ign.fin", 1'b0, 1'b1);
    check("ign.result", Result, 16'h000A);
    tick();
    check_flags("ign.after", 1'b0, 1'b0);
    tick();

    // Back-to-back: start held through DONE accepts the next operation.
    start = 1'b1;
    A     = 16'h0102;
    B     = 16'h0304;
    tick();
    A     = 16'h0001;
    B     = 16'h0000;
    tick();
    tick();
    tick();
    tick();
    check_flags("b2b.first", 1'b0, 1'b1);
    check("b2b.first_result", Result, 16'h000A);
    tick();
    start = 1'b0;
    check_flags("b2b.accept", 1'b1, 1'b0);
    check("b2b.accept_result", Result, 16'h000A);
    tick();
    tick();
    tick();
    check_flags("b2b.s4", 1'b1, 1'b0);
    tick();
    check_flags("b2b.second", 1'b0, 1'b1);
    check("b2b.second_result", Result, 16'h0001);
    tick();

    // Reset in S2 aborts the operation and clears Result.
    start = 1'b1;
    A     = 16'h0102;
    B     = 16'h0304;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_flags("abort", 1'b0, 1'b0);
    check("abort.result", Result, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_flags("abort.quiet", 1'b0, 1'b0);
    end
    run_op("post_abort", 16'h0A0A, 16'h0000, 16'h0014);
    tick();
    check_flags("end", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
